param_counter_hex: RTL and testbench

- Parametrised modulo-N up/down counter with synchronous clear, parallel load and a registered wrap pulse.
- Drives one 7-segment hex digit per nibble of the count.
- Successor to the board-level 16-bit enable/clear counter with HEX readout. Used as a timebase or event counter feeding HEX displays in lab top levels.

---
 rtl/param_counter_hex.sv | 103 ++++++++++
 tb/tb_param_counter_hex.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/param_counter_hex.sv
// Modulo-N up/down counter with clear, load, wrap pulse and hex readout.
// Define COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module param_counter_hex #(
  parameter int WIDTH = 16,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     clr_n,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_val,
  input  logic                     en,
  input  logic                     up,
  output logic [WIDTH-1:0]         count,
  output logic                     wrap,
  output logic [7*(WIDTH/4)-1:0]   hex
);

  localparam int NUM_DIGITS = WIDTH / 4;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_d, wrap_q;
  logic             load_ok;

  assign load_ok = 64'(load_val) < MODULUS;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (!clr_n) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_ok ? load_val : MAX_VAL;
    end else if (en) begin
      if (up) begin
        if (count_q == MAX_VAL) begin
          wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d = '0;
`else
          count_d = MAX_VAL;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  // segment order a..g from MSB to LSB, active-low
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign hex[7*k +: 7] = seg7(count_q[4*k +: 4]);
  end

endmodule

// File: tb/tb_param_counter_hex.sv
// Scoreboard bench for param_counter_hex: 16-bit full-range and 8-bit mod-60.
// Follows COUNTER_SATURATE_EN when the same define is given to the bench.
module tb_param_counter_hex;

  logic clock = 1'b0;
  logic resetn = 1'b0;

  logic        clr_a = 1'b1, ld_a = 1'b0, en_a = 1'b0, up_a = 1'b1;
  logic [15:0] lv_a = '0;
  logic [15:0] count_a;
  logic        wrap_a;
  logic [27:0] hex_a;

  logic        clr_b = 1'b1, ld_b = 1'b0, en_b = 1'b0, up_b = 1'b1;
  logic [7:0]  lv_b = '0;
  logic [7:0]  count_b;
  logic        wrap_b;
  logic [13:0] hex_b;

  always #5 clock = ~clock;

  param_counter_hex #(.WIDTH(16)) u_a (
    .clock(clock), .resetn(resetn), .clr_n(clr_a), .load(ld_a),
    .load_val(lv_a), .en(en_a), .up(up_a),
    .count(count_a), .wrap(wrap_a), .hex(hex_a)
  );

  param_counter_hex #(.WIDTH(8), .MODULUS(60)) u_b (
    .clock(clock), .resetn(resetn), .clr_n(clr_b), .load(ld_b),
    .load_val(lv_b), .en(en_b), .up(up_b),
    .count(count_b), .wrap(wrap_b), .hex(hex_b)
  );

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    bit              sel;
    longint unsigned cnt;
    bit              w;
    string           tag;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  longint unsigned ma = 0, mb = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] hex16(input logic [15:0] v);
    logic [27:0] h;
    for (int k = 0; k < 4; k++) h[7*k +: 7] = SEG[v[4*k +: 4]];
    return h;
  endfunction

  function automatic void model(
    input longint unsigned md, input longint unsigned cur,
    input bit c, input bit l, input longint unsigned lv,
    input bit e, input bit u,
    output longint unsigned nx, output bit w);
    nx = cur;
    w  = 1'b0;
    if (!c) nx = 0;
    else if (l) nx = (lv < md) ? lv : md - 1;
    else if (e) begin
      if (u) begin
        if (cur == md - 1) begin
          w = 1'b1;
`ifdef COUNTER_SATURATE_EN
          nx = cur;
`else
          nx = 0;
`endif
        end else nx = cur + 1;
      end else begin
        if (cur == 0) begin
          w = 1'b1;
`ifdef COUNTER_SATURATE_EN
          nx = 0;
`else
          nx = md - 1;
`endif
        end else nx = cur - 1;
      end
    end
  endfunction

  task automatic idle_all();
    clr_a = 1'b1; ld_a = 1'b0; en_a = 1'b0;
    clr_b = 1'b1; ld_b = 1'b0; en_b = 1'b0;
  endtask

  task automatic cyc(input bit sel, input bit c, input bit l,
                     input logic [15:0] lv, input bit e, input bit u,
                     input string tag);
    exp_t x;
    bit w;
    logic [27:0] eh;
    @(negedge clock);
    idle_all();
    if (!sel) begin
      clr_a = c; ld_a = l; lv_a = lv; en_a = e; up_a = u;
      model(64'h10000, ma, c, l, 64'(lv), e, u, ma, w);
      x.cnt = ma;
    end else begin
      clr_b = c; ld_b = l; lv_b = lv[7:0]; en_b = e; up_b = u;
      model(64'd60, mb, c, l, 64'(lv[7:0]), e, u, mb, w);
      x.cnt = mb;
    end
    x.sel = sel; x.w = w; x.tag = tag;
    sb.push_back(x);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    eh = hex16(16'(x.cnt));
    if (!x.sel) begin
      check({x.tag, "/cnt"}, 64'(count_a), 64'(x.cnt));
      check({x.tag, "/wrap"}, 64'(wrap_a), 64'(x.w));
      check({x.tag, "/hex"}, 64'(hex_a), 64'(eh));
    end else begin
      check({x.tag, "/cnt"}, 64'(count_b), 64'(x.cnt));
      check({x.tag, "/wrap"}, 64'(wrap_b), 64'(x.w));
      check({x.tag, "/hex"}, 64'(hex_b), 64'(eh[13:0]));
    end
  endtask

  task automatic async_rst(input string tag);
    @(negedge clock);
    idle_all();
    #2 resetn = 1'b0;
    #1;
    check({tag, "/cnt_a"}, 64'(count_a), 64'd0);
    check({tag, "/wrap_a"}, 64'(wrap_a), 64'd0);
    check({tag, "/hex_a"}, 64'(hex_a), 64'(hex16(16'h0)));
    check({tag, "/cnt_b"}, 64'(count_b), 64'd0);
    check({tag, "/wrap_b"}, 64'(wrap_b), 64'd0);
    ma = 0;
    mb = 0;
    #1 resetn = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst/cnt_a", 64'(count_a), 64'd0);
    check("rst/wrap_a", 64'(wrap_a), 64'd0);
    check("rst/hex_a", 64'(hex_a), 64'(hex16(16'h0)));
    check("rst/cnt_b", 64'(count_b), 64'd0);
    @(negedge clock);
    resetn = 1'b1;

    cyc(0, 1, 1, 16'hFFFE, 0, 1, "a_ld_fffe");
    cyc(0, 1, 0, 16'h0, 1, 1, "a_up_ffff");
    cyc(0, 1, 0, 16'h0, 1, 1, "a_up_roll");
    cyc(0, 1, 0, 16'h0, 0, 1, "a_hold");
    cyc(0, 1, 0, 16'h0, 1, 0, "a_dn_roll");
    cyc(0, 1, 0, 16'h0, 1, 1, "a_dir_flip");

    cyc(0, 1, 1, 16'hFFFF, 0, 1, "a_ld_ffff");
    cyc(0, 1, 0, 16'h0, 1, 1, "a_wrap_pend");
    async_rst("rst_wrap");

    cyc(0, 1, 1, 16'h1234, 0, 1, "a_ld_1234");
    async_rst("rst_1234");
    cyc(0, 1, 0, 16'h0, 0, 1, "a_post_rst");

    cyc(0, 1, 1, 16'hA5C3, 0, 1, "a_ld_a5c3");
    check("hex_a5c3", 64'(hex_a),
          64'({7'b0001000, 7'b0100100, 7'b0110001, 7'b0000110}));

    cyc(1, 1, 1, 16'd58, 0, 1, "b_ld58");
    cyc(1, 1, 0, 16'd0, 1, 1, "b_up59");
    cyc(1, 1, 0, 16'd0, 1, 1, "b_up0");
    cyc(1, 1, 0, 16'd0, 1, 1, "b_up1");
    cyc(1, 1, 0, 16'd0, 1, 0, "b_dn0");
    cyc(1, 1, 0, 16'd0, 1, 0, "b_dn59");
    cyc(1, 1, 1, 16'd200, 0, 1, "b_clamp");
    cyc(1, 1, 1, 16'd5, 1, 1, "b_ld_over_en");
    cyc(1, 0, 1, 16'd7, 1, 1, "b_clr_over_ld");

    cyc(1, 1, 1, 16'd59, 0, 1, "b_ld59");
    cyc(1, 1, 0, 16'd0, 1, 1, "b_top1");
    cyc(1, 1, 0, 16'd0, 1, 1, "b_top2");
    cyc(1, 1, 0, 16'd0, 1, 1, "b_top3");
    cyc(1, 1, 0, 16'd0, 1, 0, "b_back_dn");

    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 5) == 0),
          16'($urandom),
          ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          "rnd");
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
